// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the main controller and the RV32I multi-cycle datapath.
// master: controller side (samples op/mem_ready, drives selects, strobes and debug).
// slave : datapath side (drives op/mem_ready, consumes controls).
// Signals: op[6:0], mem_ready, MemReq, MemWrite, RegWrite, IRWrite, AdrSrc,
//          PCUpdate, Branch, ResultSrc[1:0], ALUSrcA[1:0], ALUSrcB[1:0],
//          ALUOp[1:0], ImmSrc[2:0], trap, trap_cause[1:0], state[3:0].
interface multicycle_ctrl_fsm_if;
  logic [6:0] op;
  logic       mem_ready;
  logic       MemReq;
  logic       MemWrite;
  logic       RegWrite;
  logic       IRWrite;
  logic       AdrSrc;
  logic       PCUpdate;
  logic       Branch;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [2:0] ImmSrc;
  logic       trap;
  logic [1:0] trap_cause;
  logic [3:0] state;

  modport master (
    input  op, mem_ready,
    output MemReq, MemWrite, RegWrite, IRWrite, AdrSrc, PCUpdate, Branch,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, trap, trap_cause, state
  );

  modport slave (
    output op, mem_ready,
    input  MemReq, MemWrite, RegWrite, IRWrite, AdrSrc, PCUpdate, Branch,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, trap, trap_cause, state
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the RV32I multi-cycle core: sequences fetch/decode/execute,
// waits on mem_ready in memory states, times out stalled accesses and parks in a
// sticky TRAP state on illegal opcodes or bus timeouts.
// Ports: clk, reset (synchronous, active-low), bus (controller modport of
//        multicycle_ctrl_fsm_if carrying op/mem_ready in and all controls out).
module multicycle_ctrl_fsm #(
  parameter int unsigned MEM_HANDSHAKE = 1,
  parameter int unsigned MEM_TIMEOUT   = 15,
  parameter int unsigned TRAP_ILLEGAL  = 1
) (
  input logic                   clk,
  input logic                   reset,
  multicycle_ctrl_fsm_if.master bus
);

  localparam int unsigned CNT_W      = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam bit          TIMEOUT_EN = (MEM_TIMEOUT != 0) && (MEM_HANDSHAKE != 0);
  localparam bit          HS_EN      = (MEM_HANDSHAKE != 0);
  localparam bit          TRAP_EN    = (TRAP_ILLEGAL != 0);

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_RTYPE  = 7'h33;
  localparam logic [6:0] OP_ITYPE  = 7'h13;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_TRAP     = 4'd15
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;

  logic ready;
  logic mem_state;
  logic timed_out;

  // State, wait counter and trap cause registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // Next state, counter update and per-state control decode.
  always_comb begin
    state_d        = state_q;
    cause_d        = cause_q;
    cnt_d          = '0;
    bus.MemReq     = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.PCUpdate   = 1'b0;
    bus.Branch     = 1'b0;
    bus.ResultSrc  = 2'b00;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ALUOp      = 2'b00;
    bus.ImmSrc     = 3'b000;
    bus.trap       = 1'b0;
    bus.trap_cause = cause_q;
    bus.state      = state_q;

    ready     = HS_EN ? bus.mem_ready : 1'b1;
    mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    timed_out = TIMEOUT_EN && mem_state && !ready && (cnt_q == CNT_W'(MEM_TIMEOUT));

    case (state_q)
      S_FETCH: begin
        bus.MemReq    = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.IRWrite   = ready;
        bus.PCUpdate  = ready;
        if (ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
        if (bus.op == OP_BRANCH)   bus.ImmSrc = 3'b010;
        else if (bus.op == OP_JAL) bus.ImmSrc = 3'b011;
        case (bus.op)
          OP_LOAD, OP_STORE, OP_JALR: state_d = S_MEMADR;
          OP_RTYPE:                   state_d = S_EXECR;
          OP_ITYPE:                   state_d = S_EXECI;
          OP_BRANCH:                  state_d = S_BRANCH;
          OP_JAL:                     state_d = S_JAL;
          OP_LUI:                     state_d = S_LUI;
          OP_AUIPC:                   state_d = S_AUIPC;
          default: begin
            if (TRAP_EN) begin
              state_d = S_TRAP;
              cause_d = 2'b01;
            end else begin
              state_d = S_FETCH;
            end
          end
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        bus.ImmSrc  = (bus.op == OP_STORE) ? 3'b001 : 3'b000;
        // Only load/store/jalr reach here; anything else would just refetch.
        if (bus.op == OP_LOAD)       state_d = S_MEMREAD;
        else if (bus.op == OP_STORE) state_d = S_MEMWRITE;
        else if (bus.op == OP_JALR)  state_d = S_JALR;
        else                         state_d = S_FETCH;
      end
      S_MEMREAD: begin
        bus.MemReq = 1'b1;
        bus.AdrSrc = 1'b1;
        if (ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite  = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWRITE: begin
        bus.MemReq   = 1'b1;
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = 1'b1;
        if (ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUOp   = 2'b10;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        bus.RegWrite = 1'b1;
        state_d      = S_FETCH;
      end
      S_EXECI: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        bus.ALUOp   = 2'b10;
        state_d     = S_ALUWB;
      end
      S_JAL: begin
        bus.PCUpdate = 1'b1;
        bus.ALUSrcA  = 2'b01;
        bus.ALUSrcB  = 2'b10;
        bus.ImmSrc   = 3'b011;
        state_d      = S_ALUWB;
      end
      S_BRANCH: begin
        bus.Branch  = 1'b1;
        bus.ALUSrcA = 2'b10;
        bus.ALUOp   = 2'b01;
        bus.ImmSrc  = 3'b010;
        state_d     = S_FETCH;
      end
      S_JALR: begin
        bus.PCUpdate = 1'b1;
        bus.ALUSrcA  = 2'b01;
        bus.ALUSrcB  = 2'b10;
        state_d      = S_ALUWB;
      end
      S_LUI: begin
        bus.ALUSrcA = 2'b11;
        bus.ALUSrcB = 2'b01;
        bus.ImmSrc  = 3'b100;
        state_d     = S_ALUWB;
      end
      S_AUIPC: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
        bus.ImmSrc  = 3'b100;
        state_d     = S_ALUWB;
      end
      S_TRAP: begin
        bus.trap = 1'b1;
      end
      default: begin
        // Unused code 14: outputs idle, recover to FETCH.
        state_d = S_FETCH;
      end
    endcase

    // A stalled access that exhausts its budget traps; a same-cycle ready wins.
    if (timed_out) begin
      state_d = S_TRAP;
      cause_d = 2'b10;
    end

    // Count only while holding in a memory state; any state change restarts at 0.
    if (TIMEOUT_EN && mem_state && !ready && (state_d == state_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: three configurations driven by
// directed and random instruction streams, checked against a per-instruction
// path model built from the documented latency and timeout rules.
module tb_multicycle_ctrl_fsm;

  localparam int unsigned CFG_HS[3] = '{1, 1, 0};
  localparam int unsigned CFG_TO[3] = '{3, 0, 15};
  localparam int unsigned CFG_TI[3] = '{1, 0, 1};

  localparam logic [6:0] VALID_OPS[9] = '{7'h03, 7'h23, 7'h67, 7'h33, 7'h13,
                                          7'h63, 7'h6F, 7'h37, 7'h17};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  op_v   [3];
  logic        rdy_v  [3];
  logic [18:0] vec_v  [3];
  logic [3:0]  st_v   [3];
  logic [1:0]  cause_v[3];

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    multicycle_ctrl_fsm_if bus ();

    multicycle_ctrl_fsm #(
      .MEM_HANDSHAKE(CFG_HS[g]),
      .MEM_TIMEOUT  (CFG_TO[g]),
      .TRAP_ILLEGAL (CFG_TI[g])
    ) u_dut (
      .clk  (clk),
      .reset(rst_n),
      .bus  (bus.master)
    );

    assign bus.op        = op_v[g];
    assign bus.mem_ready = rdy_v[g];
    assign vec_v[g] = {bus.MemReq, bus.MemWrite, bus.RegWrite, bus.IRWrite, bus.AdrSrc,
                       bus.PCUpdate, bus.Branch, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB,
                       bus.ALUOp, bus.ImmSrc, bus.trap};
    assign st_v[g]    = bus.state;
    assign cause_v[g] = bus.trap_cause;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected control word for a state, straight from the per-state output table.
  function automatic logic [18:0] exp_vec(input int d, input logic [3:0] st,
                                          input logic [6:0] o, input logic r);
    logic mreq, mwr, rwr, irw, adr, pcu, br, trp;
    logic [1:0] rs, sa, sb, ao;
    logic [2:0] imm;
    logic re;
    {mreq, mwr, rwr, irw, adr, pcu, br, trp} = '0;
    {rs, sa, sb, ao} = '0;
    imm = 3'b000;
    re  = (CFG_HS[d] != 0) ? r : 1'b1;
    case (st)
      4'd0:  begin mreq = 1; sb = 2'b10; rs = 2'b10; irw = re; pcu = re; end
      4'd1:  begin sa = 2'b01; sb = 2'b01;
                   imm = (o == 7'h63) ? 3'b010 : (o == 7'h6F) ? 3'b011 : 3'b000; end
      4'd2:  begin sa = 2'b10; sb = 2'b01; imm = (o == 7'h23) ? 3'b001 : 3'b000; end
      4'd3:  begin mreq = 1; adr = 1; end
      4'd4:  begin rs = 2'b01; rwr = 1; end
      4'd5:  begin mreq = 1; adr = 1; mwr = 1; end
      4'd6:  begin sa = 2'b10; ao = 2'b10; end
      4'd7:  begin rwr = 1; end
      4'd8:  begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
      4'd9:  begin pcu = 1; sa = 2'b01; sb = 2'b10; imm = 3'b011; end
      4'd10: begin br = 1; sa = 2'b10; ao = 2'b01; imm = 3'b010; end
      4'd11: begin pcu = 1; sa = 2'b01; sb = 2'b10; end
      4'd12: begin sa = 2'b11; sb = 2'b01; imm = 3'b100; end
      4'd13: begin sa = 2'b01; sb = 2'b01; imm = 3'b100; end
      4'd15: begin trp = 1; end
      default: ;
    endcase
    return {mreq, mwr, rwr, irw, adr, pcu, br, rs, sa, sb, ao, imm, trp};
  endfunction

  // One clock cycle: drive inputs just after the edge, check mid-cycle.
  task automatic cyc(input int d, input logic [3:0] st, input logic [6:0] o,
                     input logic r, input logic [1:0] cause);
    op_v[d]  = o;
    rdy_v[d] = r;
    @(negedge clk);
    check_eq($sformatf("d%0d_st%0d_state", d, st), 32'(st_v[d]), 32'(st));
    check_eq($sformatf("d%0d_st%0d_ctrl", d, st), 32'(vec_v[d]), 32'(exp_vec(d, st, o, r)));
    check_eq($sformatf("d%0d_st%0d_cause", d, st), 32'(cause_v[d]), 32'(cause));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Runs one instruction: builds its state path, stretches memory steps by the
  // wait count (fw for fetch, mw for the data access, -1 = random) and applies
  // the timeout budget. Reports whether it ended in TRAP and with which cause.
  task automatic run_instr(input int d, input logic [6:0] o, input int fw, input int mw,
                           output bit trapped, output logic [1:0] tc);
    int path[$];
    int w;
    logic [3:0] st;
    logic [6:0] oo;
    trapped = 1'b0;
    tc      = 2'b00;
    path    = {0, 1};
    case (o)
      7'h33: path = {path, 6, 7};
      7'h13: path = {path, 8, 7};
      7'h37: path = {path, 12, 7};
      7'h17: path = {path, 13, 7};
      7'h6F: path = {path, 9, 7};
      7'h63: path = {path, 10};
      7'h03: path = {path, 2, 3, 4};
      7'h23: path = {path, 2, 5};
      7'h67: path = {path, 2, 11, 7};
      default: if (CFG_TI[d] != 0) path = {path, 15};
    endcase
    foreach (path[i]) begin
      st = 4'(path[i]);
      oo = (st == 4'd0) ? 7'($urandom) : o;
      if (st == 4'd15) begin
        cyc(d, st, oo, 1'($urandom), 2'b01);
        trapped = 1'b1;
        tc      = 2'b01;
        return;
      end
      if ((st == 4'd0 || st == 4'd3 || st == 4'd5) && CFG_HS[d] != 0) begin
        w = (st == 4'd0) ? fw : mw;
        if (w < 0) w = $urandom_range(0, 5);
        if (CFG_TO[d] != 0 && w > int'(CFG_TO[d])) begin
          for (int j = 0; j <= int'(CFG_TO[d]); j++) cyc(d, st, oo, 1'b0, 2'b00);
          cyc(d, 4'd15, oo, 1'($urandom), 2'b10);
          trapped = 1'b1;
          tc      = 2'b10;
          return;
        end
        for (int j = 0; j <= w; j++) cyc(d, st, oo, (j == w), 2'b00);
      end else begin
        cyc(d, st, oo, 1'($urandom), 2'b00);
      end
    end
  endtask

  function automatic logic [6:0] pick_op();
    logic [6:0] o;
    if ($urandom_range(0, 9) < 9) return VALID_OPS[$urandom_range(0, 8)];
    do o = 7'($urandom); while (o inside {VALID_OPS});
    return o;
  endfunction

  initial begin
    bit         trapped;
    logic [1:0] tc;
    logic [6:0] o;

    for (int i = 0; i < 3; i++) begin
      op_v[i]  = 7'h00;
      rdy_v[i] = 1'b0;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // R-type after reset, first with two fetch wait cycles, then at full speed.
    run_instr(0, 7'h33, 2, 0, trapped, tc);
    run_instr(0, 7'h33, 0, 0, trapped, tc);
    // lw with two wait cycles in MEMREAD (7 cycles total).
    run_instr(0, 7'h03, 0, 2, trapped, tc);
    // sw ready on the 4th MEMWRITE cycle: completes, no trap.
    run_instr(0, 7'h23, 0, 3, trapped, tc);
    // sw stuck: four MemWrite cycles then TRAP with timeout cause.
    run_instr(0, 7'h23, 0, 9, trapped, tc);
    cyc(0, 4'd15, 7'h00, 1'b1, tc);
    do_reset();
    // LUI then JALR.
    run_instr(0, 7'h37, 0, 0, trapped, tc);
    run_instr(0, 7'h67, 0, 0, trapped, tc);
    // Illegal opcode traps; reset while in TRAP clears it.
    run_instr(0, 7'h7F, 0, 0, trapped, tc);
    cyc(0, 4'd15, 7'h7F, 1'b1, tc);
    rst_n = 1'b0;
    cyc(0, 4'd15, 7'h7F, 1'b1, tc);
    rst_n = 1'b1;
    cyc(0, 4'd0, 7'h7F, 1'b0, 2'b00);

    // Reset during a MEMWRITE wait: back to FETCH with no write strobe.
    do_reset();
    cyc(0, 4'd0, 7'h00, 1'b1, 2'b00);
    cyc(0, 4'd1, 7'h23, 1'b1, 2'b00);
    cyc(0, 4'd2, 7'h23, 1'b1, 2'b00);
    cyc(0, 4'd5, 7'h23, 1'b0, 2'b00);
    rst_n = 1'b0;
    cyc(0, 4'd5, 7'h23, 1'b0, 2'b00);
    rst_n = 1'b1;
    cyc(0, 4'd0, 7'h23, 1'b0, 2'b00);

    // Illegal opcode is skipped when trapping is disabled.
    do_reset();
    run_instr(1, 7'h7F, 0, 0, trapped, tc);
    run_instr(1, 7'h33, 0, 0, trapped, tc);

    // Random streams on every configuration.
    for (int d = 0; d < 3; d++) begin
      do_reset();
      for (int n = 0; n < 60; n++) begin
        o = pick_op();
        run_instr(d, o, -1, -1, trapped, tc);
        if (trapped) begin
          cyc(d, 4'd15, 7'($urandom), 1'($urandom), tc);
          do_reset();
        end
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Main control FSM for the RV32I multi-cycle core, the next generation of the current main controller. It adds a memory ready handshake with wait states, a configurable memory timeout counter, a proper JALR path, LUI/AUIPC support, and a sticky trap state for illegal opcodes and bus timeouts. It drives the existing datapath mux selects and the ALU decoder's ALUOp, and exposes its state and a trap cause for debug.

Parameters:
MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready is ignored and treated as 1.
MEM_TIMEOUT, 15, maximum low mem_ready cycles tolerated in one memory state; 0 disables the timeout.
TRAP_ILLEGAL, 1, 1 = an undefined opcode enters TRAP; 0 = DECODE returns to FETCH, skipping the instruction.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
op  in  7  opcode field from the instruction register
mem_ready  in  1  memory completes the current access this cycle
MemReq  out  1  memory access request
MemWrite  out  1  store strobe
RegWrite  out  1  register file write enable
IRWrite  out  1  instruction register load
AdrSrc  out  1  0 = PC, 1 = ALUOut
PCUpdate  out  1  unconditional PC load
Branch  out  1  conditional PC load, qualified by Zero in the datapath
ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1, 11 = zero
ALUSrcB  out  2  00 = rs2, 01 = Imm, 10 = constant 4
ALUOp  out  2  00 = add, 01 = branch compare, 10 = funct decode
ImmSrc  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U
trap  out  1  high while in TRAP
trap_cause  out  2  00 = none, 01 = illegal opcode, 10 = memory timeout
state  out  4  current state encoding

Behaviour:
- Sequencing: present state is registered. Outputs decode combinationally from state, plus op in DECODE/MEMADR and mem_ready in the memory states. Every output not listed for a state is 0.
- Reset: when reset=0 at a clock edge, the next state is FETCH (0), the timeout counter clears and trap_cause becomes 00. While in FETCH after reset, MemReq=1 and all strobes are 0 until mem_ready.
- State encodings and per-state outputs:
  - FETCH(0): MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10.
    - IRWrite=PCUpdate=mem_ready.
    - On mem_ready go to DECODE; otherwise stay.
  - DECODE(1): ALUSrcA=01, ALUSrcB=01, ALUOp=00.
    - ImmSrc: 010 for op 63h, 011 for op 6Fh, 000 otherwise.
    - Transitions: 03h/23h/67h go to MEMADR; 33h to EXECR; 13h to EXECI; 63h to BRANCH; 6Fh to JAL; 37h to LUI; 17h to AUIPC.
    - Any other op goes to TRAP (cause 01), or to FETCH if TRAP_ILLEGAL=0.
  - MEMADR(2): ALUSrcA=10, ALUSrcB=01, ImmSrc=001 if op=23h else 000.
    - Transitions: 03h to MEMREAD, 23h to MEMWRITE, 67h to JALR.
  - MEMREAD(3): MemReq=1, AdrSrc=1. On mem_ready go to MEMWB.
  - MEMWB(4): ResultSrc=01, RegWrite=1, then FETCH.
  - MEMWRITE(5): MemReq=1, AdrSrc=1, MemWrite=1, held for the whole state. On mem_ready go to FETCH.
  - EXECR(6): ALUSrcA=10, ALUSrcB=00, ALUOp=10, then ALUWB.
  - ALUWB(7): ResultSrc=00, RegWrite=1, then FETCH.
  - EXECI(8): ALUSrcA=10, ALUSrcB=01, ALUOp=10, ImmSrc=000, then ALUWB.
  - JAL(9): PCUpdate=1, ResultSrc=00, ALUSrcA=01, ALUSrcB=10, ImmSrc=011, then ALUWB.
  - BRANCH(10): Branch=1, ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, ImmSrc=010, then FETCH.
  - JALR(11): PCUpdate=1, ResultSrc=00, ALUSrcA=01, ALUSrcB=10, then ALUWB.
  - LUI(12): ALUSrcA=11, ALUSrcB=01, ImmSrc=100, ALUOp=00, then ALUWB.
  - AUIPC(13): ALUSrcA=01, ALUSrcB=01, ImmSrc=100, ALUOp=00, then ALUWB.
  - TRAP(15): trap=1, all strobes 0. Sticky until reset.
- Latency with mem_ready held at 1:
  - R/I/LUI/AUIPC: 4 cycles; JAL: 4.
  - JALR: 5; lw: 5; sw: 4; branch: 3.
  - Each low mem_ready cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Timeout counter:
  - Width is clog2(MEM_TIMEOUT+1).
  - It clears on entry to any memory state and increments each cycle that state sees mem_ready=0.
  - If the counter equals MEM_TIMEOUT and mem_ready=0, the next state is TRAP with cause 10.
  - mem_ready=1 in that same cycle wins: the access completes normally.
  - MEM_TIMEOUT=0 disables the counter; the FSM waits indefinitely.
- MEM_HANDSHAKE=0: every memory state lasts exactly one cycle and the counter is inert.
- Reset mid-operation:
  - Reset in any state, including a wait state or TRAP, forces FETCH on the next edge.
  - No RegWrite or MemWrite is asserted in the cycle after that edge.
- Unused state code 14: treated as FETCH on the next edge, with all outputs 0 while in it.

Test Plan:
- Reset low for 2 cycles, then op=33h with mem_ready=1: state sequence 0,1,6,7,0; RegWrite=1 only in state 7; IRWrite=1 only in state 0.
- lw (op=03h), mem_ready low for 2 cycles in MEMREAD: state 3 is held for 3 cycles; MemReq=1 and AdrSrc=1 throughout; the total instruction takes 7 cycles; then MEMWB with ResultSrc=01.
- sw with MEM_TIMEOUT=3 and mem_ready stuck at 0: MemWrite=1 for 4 cycles, then state=15, trap=1, trap_cause=10.
  - Same case with mem_ready rising on the 4th cycle: the FSM returns to FETCH and trap stays 0.
- op=7Fh: TRAP_ILLEGAL=1 gives state 15 and trap_cause=01 after DECODE; TRAP_ILLEGAL=0 gives a return to state 0 with no RegWrite.
- LUI (37h) then JALR (67h): LUI shows ALUSrcA=11 and ImmSrc=100 then ALUWB; JALR runs 1,2,11,7 with PCUpdate=1 and ResultSrc=00 in state 11.
- Reset pulsed low while in MEMWRITE wait and while in TRAP: next state 0; trap and trap_cause clear; MemWrite=0 in the following cycle.
